// File: rtl/serial_pattern_tx.sv
// ---------------------------------------------------------------------------
// serial_pattern_tx
//
// Parallel-to-serial pattern transmitter. Drives the single-bit serial line
// that the sequence-detector FSMs sample once per clock. A WIDTH-bit word is
// accepted over a valid/ready handshake and shifted out MSB-first. After the
// last data bit the line is held at IDLE_LEVEL for GAP_CYCLES cycles before
// the next word can be accepted.
//
// Parameters
//   WIDTH       bits per word (>= 2)
//   GAP_CYCLES  idle-level cycles after each word (>= 0)
//   IDLE_LEVEL  line level whenever no data bit is being driven
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   data_i   in   [WIDTH-1:0] word to send, sampled only on accept
//   valid_i  in   data_i is valid
//   ready_o  out  a word can be accepted this cycle
//   ser_o    out  serial line (registered)
//   frame_o  out  high while ser_o carries a data bit
//   busy_o   out  high while shifting or in the inter-word gap
//   done_o   out  one-cycle pulse in the cycle after the last data bit
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module serial_pattern_tx #(
    parameter int   WIDTH      = 32,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W    = $clog2(WIDTH);
    // The gap counter still needs a legal width when the gap is 0 or 1 cycle.
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    localparam logic [CNT_W-1:0] BIT_LAST_C = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   shift_q,   shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               ser_q,     ser_d;
    logic               frame_q,   frame_d;
    logic               busy_q,    busy_d;
    logic               ready_q,   ready_d;
    logic               done_q,    done_d;

    logic               accept;

    // ready_q is only ever high in IDLE, so this cannot fire mid-word.
    assign accept = valid_i && ready_q;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ser_q     <= IDLE_LEVEL;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ser_q     <= ser_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and registered-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ser_d     = ser_q;
        frame_d   = frame_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ser_d = IDLE_LEVEL;
                if (accept) begin
                    // The MSB goes straight onto the line at the accept edge,
                    // so the shift register keeps only the remaining bits.
                    state_d   = ST_SHIFT;
                    ser_d     = data_i[WIDTH-1];
                    shift_d   = {data_i[WIDTH-2:0], 1'b0};
                    bit_cnt_d = '0;
                    frame_d   = 1'b1;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST_C) begin
                    // The cycle after the last bit carries done_o and is
                    // already the first gap cycle (or idle when there is no gap).
                    ser_d     = IDLE_LEVEL;
                    frame_d   = 1'b0;
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    ser_d     = shift_q[WIDTH-1];
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                ser_d = IDLE_LEVEL;
                if (gap_cnt_q == GAP_LAST_C) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                    ready_d   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d   = ST_IDLE;
                ser_d     = IDLE_LEVEL;
                frame_d   = 1'b0;
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    assign ready_o = ready_q;
    assign ser_o   = ser_q;
    assign frame_o = frame_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] data32;
    logic        valid32;
    logic        ready32, ser32, frame32, busy32, done32;

    logic [7:0]  data8;
    logic        valid8;
    logic        ready8, ser8, frame8, busy8, done8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic exp32[$];
    logic exp8[$];
    int   exp_done32 = 0;
    int   got_done32 = 0;
    int   exp_done8  = 0;
    int   got_done8  = 0;

    serial_pattern_tx #(.WIDTH(32), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data32),
        .valid_i (valid32),
        .ready_o (ready32),
        .ser_o   (ser32),
        .frame_o (frame32),
        .busy_o  (busy32),
        .done_o  (done32)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data8),
        .valid_i (valid8),
        .ready_o (ready8),
        .ser_o   (ser8),
        .frame_o (frame8),
        .busy_o  (busy8),
        .done_o  (done8)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor for the 32-bit instance: every framed bit is popped from the
    // scoreboard, every unframed cycle must show the idle level.
    initial begin
        logic pf, pd;
        pf = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pf = 1'b0;
                pd = 1'b0;
            end else begin
                if (frame32) begin
                    if (exp32.size() == 0) chk("unexpected_bit32", 32'(ser32), 32'hDEAD);
                    else                   chk("bit32", 32'(ser32), 32'(exp32.pop_front()));
                end else begin
                    chk("idle32", 32'(ser32), 32'h0);
                end
                chk("rdy_vs_busy32", 32'(ready32), 32'(!busy32));
                if (done32) begin
                    chk("done_after_frame32", 32'(pf), 32'h1);
                    chk("done_single32", 32'(pd), 32'h0);
                    got_done32++;
                end
                pf = frame32;
                pd = done32;
            end
        end
    end

    initial begin
        logic pf, pd;
        pf = 1'b0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pf = 1'b0;
                pd = 1'b0;
            end else begin
                if (frame8) begin
                    if (exp8.size() == 0) chk("unexpected_bit8", 32'(ser8), 32'hDEAD);
                    else                  chk("bit8", 32'(ser8), 32'(exp8.pop_front()));
                end else begin
                    chk("idle8", 32'(ser8), 32'h1);
                end
                chk("rdy_vs_busy8", 32'(ready8), 32'(!busy8));
                if (done8) begin
                    chk("done_after_frame8", 32'(pf), 32'h1);
                    chk("done_single8", 32'(pd), 32'h0);
                    got_done8++;
                end
                pf = frame8;
                pd = done8;
            end
        end
    end

    // Push the expected bits, hold valid until accepted, return the accept cycle.
    task automatic send32(input logic [31:0] w, output int t);
        logic acc;
        for (int i = 31; i >= 0; i--) exp32.push_back(w[i]);
        exp_done32++;
        data32  = w;
        valid32 = 1'b1;
        acc     = 1'b0;
        t       = -1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(posedge clk);
            if (ready32) begin
                acc = 1'b1;
                t   = cyc;
            end
        end
        #1;
        valid32 = 1'b0;
        chk("accept32", 32'(acc), 32'h1);
    endtask

    task automatic send8(input logic [7:0] w);
        logic acc;
        for (int i = 7; i >= 0; i--) exp8.push_back(w[i]);
        exp_done8++;
        data8  = w;
        valid8 = 1'b1;
        acc    = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(posedge clk);
            if (ready8) acc = 1'b1;
        end
        #1;
        valid8 = 1'b0;
        chk("accept8", 32'(acc), 32'h1);
    endtask

    // Wait for done_o, then check the two gap cycles and the return to ready.
    task automatic wait_done_gap32();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        chk("done_seen32", 32'(seen), 32'h1);
        chk("gap1_busy32", 32'(busy32), 32'h1);
        @(negedge clk);
        chk("gap2_done_low32", 32'(done32), 32'h0);
        chk("gap2_busy32", 32'(busy32), 32'h1);
        @(negedge clk);
        chk("after_gap_ready32", 32'(ready32), 32'h1);
        chk("after_gap_busy32", 32'(busy32), 32'h0);
    endtask

    initial begin
        int t1, t2, t3;
        logic seen;
        rst_n   = 1'b0;
        data32  = '0;
        valid32 = 1'b0;
        data8   = '0;
        valid8  = 1'b0;

        // Reset values
        #12;
        chk("rst_ser32",   32'(ser32),   32'h0);
        chk("rst_ready32", 32'(ready32), 32'h1);
        chk("rst_busy32",  32'(busy32),  32'h0);
        chk("rst_frame32", 32'(frame32), 32'h0);
        chk("rst_done32",  32'(done32),  32'h0);
        chk("rst_ser8",    32'(ser8),    32'h1);
        chk("rst_ready8",  32'(ready8),  32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word with gap timing
        send32(32'hAAAAAAAA, t1);
        wait_done_gap32();

        // Back-to-back with valid held
        send32(32'hAAAAAAAA, t1);
        send32(32'h55555555, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd35);
        wait_done_gap32();

        // valid/data pulsed while busy must be ignored
        send32(32'hAAAAAAAA, t3);
        repeat (5) @(posedge clk);
        #1;
        data32  = 32'hFFFFFFFF;
        valid32 = 1'b1;
        @(posedge clk);
        #1;
        valid32 = 1'b0;
        wait_done_gap32();
        repeat (40) @(posedge clk);
        #1;
        chk("no_extra_word_q", 32'(exp32.size()), 32'h0);

        // Reset in the middle of bit 10 of F0F0F0F0
        send32(32'hF0F0F0F0, t3);
        repeat (10) @(posedge clk);
        #2;
        chk("bit10_before_rst", 32'(ser32), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_ser32",   32'(ser32),   32'h0);
        chk("async_frame32", 32'(frame32), 32'h0);
        chk("async_ready32", 32'(ready32), 32'h1);
        chk("async_busy32",  32'(busy32),  32'h0);
        chk("async_done32",  32'(done32),  32'h0);
        exp32.delete();
        exp_done32--;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send32(32'h0000000F, t3);
        wait_done_gap32();

        // 8-bit instance, no gap, idle level 1
        send8(8'hC3);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        chk("done_seen8", 32'(seen), 32'h1);
        chk("done_ser8",   32'(ser8),   32'h1);
        chk("done_ready8", 32'(ready8), 32'h1);
        chk("done_busy8",  32'(busy8),  32'h0);
        chk("done_frame8", 32'(frame8), 32'h0);
        repeat (5) @(posedge clk);
        #1;

        chk("q32_drained",  32'(exp32.size()), 32'h0);
        chk("q8_drained",   32'(exp8.size()),  32'h0);
        chk("done_count32", 32'(got_done32),   32'(exp_done32));
        chk("done_count8",  32'(got_done8),    32'(exp_done8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
